// File: rtl/frac_interp_pkg.sv
// Shared constants and FSM encoding for the quarter-pel bilinear interpolator.
// FRAC_INTERP_ROUND_EN selects round-half-up (RND=8) instead of truncation.
package frac_interp_pkg;

    localparam int unsigned PIX_W       = 8;
    localparam int unsigned PIX_PER_ROW = 8;
    localparam int unsigned FRAC_BITS   = 2;
    localparam int unsigned ROW_W       = PIX_PER_ROW * PIX_W;
    localparam int unsigned ROW_IN_W    = ROW_W + PIX_W;
    localparam int unsigned ACC_W       = 12;

`ifdef FRAC_INTERP_ROUND_EN
    localparam int unsigned RND = 8;
`else
    localparam int unsigned RND = 0;
`endif

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/frac_interp_pix.sv
// Combinational single-pixel bilinear kernel; weights always sum to 16, so the
// 12-bit accumulator cannot overflow for 8-bit inputs.
module frac_interp_pix
    import frac_interp_pkg::*;
(
    input  logic [PIX_W-1:0]     a_i,
    input  logic [PIX_W-1:0]     b_i,
    input  logic [PIX_W-1:0]     c_i,
    input  logic [PIX_W-1:0]     d_i,
    input  logic [FRAC_BITS-1:0] fx_i,
    input  logic [FRAC_BITS-1:0] fy_i,
    output logic [PIX_W-1:0]     pix_c
);

    logic [ACC_W-1:0] wx0, wx1, wy0, wy1, acc;

    always_comb begin
        wx1   = ACC_W'(fx_i);
        wy1   = ACC_W'(fy_i);
        wx0   = ACC_W'(4) - wx1;
        wy0   = ACC_W'(4) - wy1;
        acc   = wx0 * wy0 * ACC_W'(a_i)
              + wx1 * wy0 * ACC_W'(b_i)
              + wx0 * wy1 * ACC_W'(c_i)
              + wx1 * wy1 * ACC_W'(d_i)
              + ACC_W'(RND);
        pix_c = PIX_W'(acc >> 4);
    end

endmodule

// File: rtl/frac_interp.sv
// Quarter-pel bilinear interpolator: pairs each incoming row with the previous
// one and emits eight filtered pixels per row. Rounding via FRAC_INTERP_ROUND_EN.
module frac_interp
    import frac_interp_pkg::*;
#(
    parameter int unsigned BLK_H = 8
)
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic                 in_sob,
    input  logic [ROW_IN_W-1:0]  in_row,
    input  logic [ROW_W-1:0]     in_ref,
    input  logic [FRAC_BITS-1:0] frac_x,
    input  logic [FRAC_BITS-1:0] frac_y,
    output logic [ROW_W-1:0]     filter_pix,
    output logic [ROW_W-1:0]     ref_pix,
    output logic                 input_ready,
    output logic                 blk_done,
    output logic                 sob_err
);

    localparam int unsigned CNT_W = (BLK_H > 1) ? $clog2(BLK_H) : 1;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ROW_IN_W-1:0]  prev_row_q, prev_row_d;
    logic [ROW_W-1:0]     prev_ref_q, prev_ref_d;
    logic [FRAC_BITS-1:0] fx_q, fx_d, fy_q, fy_d;
    logic [ROW_W-1:0]     filter_q, filter_d, refo_q, refo_d;
    logic                 rdy_q, rdy_d, done_q, done_d, err_q, err_d;
    logic [ROW_W-1:0]     kern_c;
    logic                 last_c;

    for (genvar k = 0; k < PIX_PER_ROW; k++) begin : g_pix
        frac_interp_pix u_pix (
            .a_i   (prev_row_q[k*PIX_W +: PIX_W]),
            .b_i   (prev_row_q[(k+1)*PIX_W +: PIX_W]),
            .c_i   (in_row[k*PIX_W +: PIX_W]),
            .d_i   (in_row[(k+1)*PIX_W +: PIX_W]),
            .fx_i  (fx_q),
            .fy_i  (fy_q),
            .pix_c (kern_c[k*PIX_W +: PIX_W])
        );
    end

    assign last_c = (cnt_q == CNT_W'(BLK_H - 1));

    // Next-state and datapath update; in_sob always restarts, even mid-block.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        prev_row_d = prev_row_q;
        prev_ref_d = prev_ref_q;
        fx_d       = fx_q;
        fy_d       = fy_q;
        filter_d   = filter_q;
        refo_d     = refo_q;
        rdy_d      = 1'b0;
        done_d     = 1'b0;
        err_d      = err_q;
        if (in_valid) begin
            if (in_sob) begin
                if (state_q == RUN) begin
                    err_d = 1'b1;
                end
                prev_row_d = in_row;
                prev_ref_d = in_ref;
                fx_d       = frac_x;
                fy_d       = frac_y;
                cnt_d      = '0;
                state_d    = RUN;
            end else if (state_q == RUN) begin
                filter_d   = kern_c;
                refo_d     = prev_ref_q;
                prev_row_d = in_row;
                prev_ref_d = in_ref;
                rdy_d      = 1'b1;
                if (last_c) begin
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            prev_row_q <= '0;
            prev_ref_q <= '0;
            fx_q       <= '0;
            fy_q       <= '0;
            filter_q   <= '0;
            refo_q     <= '0;
            rdy_q      <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            prev_row_q <= prev_row_d;
            prev_ref_q <= prev_ref_d;
            fx_q       <= fx_d;
            fy_q       <= fy_d;
            filter_q   <= filter_d;
            refo_q     <= refo_d;
            rdy_q      <= rdy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign filter_pix  = filter_q;
    assign ref_pix     = refo_q;
    assign input_ready = rdy_q;
    assign blk_done    = done_q;
    assign sob_err     = err_q;

endmodule

// File: tb/tb_frac_interp.sv
// Scoreboard bench for frac_interp: a row-level model pushes expected outputs,
// a negedge monitor pops and compares them on every input_ready pulse.
module tb_frac_interp;

    localparam int BLK_H = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_sob = 1'b0;
    logic [71:0] in_row = '0;
    logic [63:0] in_ref = '0;
    logic [1:0]  frac_x = '0;
    logic [1:0]  frac_y = '0;
    logic [63:0] filter_pix, ref_pix;
    logic        input_ready, blk_done, sob_err;

    frac_interp #(.BLK_H(BLK_H)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_sob      (in_sob),
        .in_row      (in_row),
        .in_ref      (in_ref),
        .frac_x      (frac_x),
        .frac_y      (frac_y),
        .filter_pix  (filter_pix),
        .ref_pix     (ref_pix),
        .input_ready (input_ready),
        .blk_done    (blk_done),
        .sob_err     (sob_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] filt;
        logic [63:0] refp;
        logic        done;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int passed = 0;
    int done_seen = 0;
    int rdy_seen = 0;

    logic        m_run;
    logic [71:0] m_prev_row;
    logic [63:0] m_prev_ref;
    int          m_fx, m_fy, m_cnt;
    logic        m_err;
    logic [63:0] m_last_filt, m_last_ref;

    function automatic int rnd_val();
`ifdef FRAC_INTERP_ROUND_EN
        return 8;
`else
        return 0;
`endif
    endfunction

    function automatic logic [7:0] exp_pix(int a, int b, int c, int d, int fx, int fy);
        int s;
        s = (4-fx)*(4-fy)*a + fx*(4-fy)*b + (4-fx)*fy*c + fx*fy*d + rnd_val();
        return 8'(s / 16);
    endfunction

    function automatic logic [71:0] ramp_row(int base, int step);
        logic [71:0] r;
        for (int k = 0; k < 9; k++) r[8*k +: 8] = 8'(base + k*step);
        return r;
    endfunction

    function automatic logic [71:0] rand_row();
        return {8'($urandom), $urandom, $urandom};
    endfunction

    task automatic model_reset();
        m_run = 1'b0; m_prev_row = '0; m_prev_ref = '0;
        m_fx = 0; m_fy = 0; m_cnt = 0; m_err = 1'b0;
        m_last_filt = '0; m_last_ref = '0;
        sb.delete();
    endtask

    // Drive one cycle of input, update the model and push any expected output.
    task automatic send(input logic v, input logic sob, input logic [71:0] row,
                        input logic [63:0] rf, input logic [1:0] fx, input logic [1:0] fy);
        exp_t e;
        in_valid = v; in_sob = sob; in_row = row; in_ref = rf; frac_x = fx; frac_y = fy;
        if (v) begin
            if (sob) begin
                if (m_run) m_err = 1'b1;
                m_prev_row = row; m_prev_ref = rf; m_fx = int'(fx); m_fy = int'(fy);
                m_cnt = 0; m_run = 1'b1;
            end else if (m_run) begin
                for (int k = 0; k < 8; k++)
                    e.filt[8*k +: 8] = exp_pix(int'(m_prev_row[8*k +: 8]), int'(m_prev_row[8*k+8 +: 8]),
                                               int'(row[8*k +: 8]), int'(row[8*k+8 +: 8]), m_fx, m_fy);
                e.refp = m_prev_ref;
                e.done = (m_cnt == BLK_H-1);
                sb.push_back(e);
                m_last_filt = e.filt; m_last_ref = e.refp;
                m_prev_row = row; m_prev_ref = rf;
                m_cnt++;
                if (e.done) begin m_run = 1'b0; m_cnt = 0; end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(1'b0, 1'b0, '0, '0, 2'd0, 2'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (input_ready === 1'b1) begin
            rdy_seen++;
            if (blk_done === 1'b1) done_seen++;
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_ready: got input_ready=1 want 0 (no row pending)");
            end else begin
                e = sb.pop_front();
                checks++;
                if (filter_pix !== e.filt) $display("FAIL filter_pix: got %h want %h", filter_pix, e.filt);
                else passed++;
                checks++;
                if (ref_pix !== e.refp) $display("FAIL ref_pix: got %h want %h", ref_pix, e.refp);
                else passed++;
                checks++;
                if (blk_done !== e.done) $display("FAIL blk_done: got %b want %b", blk_done, e.done);
                else passed++;
            end
        end else if (blk_done !== 1'b0) begin
            checks++;
            $display("FAIL stray_blk_done: got %b want 0 without input_ready", blk_done);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    task automatic test_reset();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (filter_pix !== 64'h0) $display("FAIL rst_filter: got %h want 0", filter_pix); else passed++;
        checks++; if (ref_pix !== 64'h0) $display("FAIL rst_ref: got %h want 0", ref_pix); else passed++;
        checks++; if (input_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", input_ready); else passed++;
        checks++; if (blk_done !== 1'b0) $display("FAIL rst_done: got %b want 0", blk_done); else passed++;
        checks++; if (sob_err !== 1'b0) $display("FAIL rst_err: got %b want 0", sob_err); else passed++;
        reset = 1'b1;
        idle(1);
    endtask

    task automatic test_flat();
        int d0 = done_seen;
        send(1'b1, 1'b1, {9{8'h40}}, {8{8'h40}}, 2'd1, 2'd3);
        for (int r = 0; r < BLK_H; r++) send(1'b1, 1'b0, {9{8'h40}}, {8{8'h40}}, 2'd0, 2'd0);
        idle(2);
        checks++; if (filter_pix !== {8{8'h40}}) $display("FAIL flat_pix: got %h want %h", filter_pix, {8{8'h40}}); else passed++;
        checks++; if (done_seen - d0 !== 1) $display("FAIL flat_done_cnt: got %0d want 1", done_seen - d0); else passed++;
        checks++; if (sb.size() !== 0) $display("FAIL flat_drain: got %0d pending want 0", sb.size()); else passed++;
    endtask

    task automatic test_phase_zero();
        logic [71:0] row;
        logic [63:0] rf;
        for (int r = 0; r <= BLK_H; r++) begin
            row = ramp_row(r*16, 1);
            rf  = ~row[63:0];
            send(1'b1, (r == 0), row, rf, 2'd0, 2'd0);
        end
        idle(2);
        row = ramp_row((BLK_H-1)*16, 1);
        checks++; if (filter_pix !== row[63:0]) $display("FAIL phase0_pix: got %h want %h", filter_pix, row[63:0]); else passed++;
        checks++; if (ref_pix !== ~row[63:0]) $display("FAIL phase0_ref: got %h want %h", ref_pix, ~row[63:0]); else passed++;
    endtask

    task automatic test_rounding();
        logic [7:0] want;
        want = (rnd_val() == 8) ? 8'd1 : 8'd0;
        send(1'b1, 1'b1, 72'h100, '0, 2'd2, 2'd0);
        send(1'b1, 1'b0, '0, '0, 2'd0, 2'd0);
        checks++; if (filter_pix[7:0] !== want) $display("FAIL half_pel_round: got %h want %h", filter_pix[7:0], want); else passed++;
        for (int r = 1; r < BLK_H; r++) send(1'b1, 1'b0, rand_row(), 64'($urandom), 2'd0, 2'd0);
        idle(2);
    endtask

    task automatic test_premature_sob();
        int d0 = done_seen;
        send(1'b1, 1'b1, rand_row(), {$urandom, $urandom}, 2'd3, 2'd1);
        for (int r = 1; r < 5; r++) send(1'b1, 1'b0, rand_row(), {$urandom, $urandom}, 2'd0, 2'd0);
        checks++; if (sob_err !== 1'b0) $display("FAIL err_before: got %b want 0", sob_err); else passed++;
        send(1'b1, 1'b1, rand_row(), {$urandom, $urandom}, 2'd2, 2'd2);
        for (int r = 0; r < BLK_H; r++) send(1'b1, 1'b0, rand_row(), {$urandom, $urandom}, 2'd0, 2'd0);
        idle(2);
        checks++; if (sob_err !== m_err) $display("FAIL sob_err: got %b want %b", sob_err, m_err); else passed++;
        checks++; if (done_seen - d0 !== 1) $display("FAIL premature_done_cnt: got %0d want 1", done_seen - d0); else passed++;
        checks++; if (sb.size() !== 0) $display("FAIL premature_drain: got %0d pending want 0", sb.size()); else passed++;
    endtask

    task automatic test_gaps();
        send(1'b1, 1'b1, rand_row(), {$urandom, $urandom}, 2'($urandom), 2'($urandom));
        for (int r = 0; r < BLK_H; r++) begin
            send(1'b1, 1'b0, rand_row(), {$urandom, $urandom}, 2'd0, 2'd0);
            send(1'b0, 1'b0, rand_row(), {$urandom, $urandom}, 2'd0, 2'd0);
            checks++; if (input_ready !== 1'b0) $display("FAIL gap_ready: got %b want 0", input_ready); else passed++;
            checks++; if (filter_pix !== m_last_filt) $display("FAIL gap_hold_pix: got %h want %h", filter_pix, m_last_filt); else passed++;
            checks++; if (ref_pix !== m_last_ref) $display("FAIL gap_hold_ref: got %h want %h", ref_pix, m_last_ref); else passed++;
        end
        idle(1);
    endtask

    task automatic test_reset_mid();
        int r0;
        send(1'b1, 1'b1, rand_row(), {$urandom, $urandom}, 2'd1, 2'd1);
        for (int r = 0; r < 3; r++) send(1'b1, 1'b0, rand_row(), {$urandom, $urandom}, 2'd0, 2'd0);
        idle(1);
        @(negedge clk); #1;
        reset = 1'b0;
        #1;
        model_reset();
        checks++; if (filter_pix !== 64'h0) $display("FAIL mid_rst_filter: got %h want 0", filter_pix); else passed++;
        checks++; if (ref_pix !== 64'h0) $display("FAIL mid_rst_ref: got %h want 0", ref_pix); else passed++;
        checks++; if (sob_err !== 1'b0) $display("FAIL mid_rst_err: got %b want 0", sob_err); else passed++;
        @(posedge clk); #1;
        reset = 1'b1;
        r0 = rdy_seen;
        for (int r = 0; r < 3; r++) send(1'b1, 1'b0, rand_row(), {$urandom, $urandom}, 2'd0, 2'd0);
        idle(2);
        checks++; if (rdy_seen - r0 !== 0) $display("FAIL ignored_rows: got %0d pulses want 0", rdy_seen - r0); else passed++;
    endtask

    task automatic test_back_to_back();
        int d0 = done_seen;
        for (int b = 0; b < 2; b++) begin
            send(1'b1, 1'b1, rand_row(), {$urandom, $urandom}, 2'($urandom), 2'($urandom));
            for (int r = 0; r < BLK_H; r++) send(1'b1, 1'b0, rand_row(), {$urandom, $urandom}, 2'd0, 2'd0);
        end
        idle(2);
        checks++; if (done_seen - d0 !== 2) $display("FAIL b2b_done_cnt: got %0d want 2", done_seen - d0); else passed++;
        checks++; if (sob_err !== 1'b0) $display("FAIL b2b_err: got %b want 0", sob_err); else passed++;
        checks++; if (sb.size() !== 0) $display("FAIL b2b_drain: got %0d pending want 0", sb.size()); else passed++;
    endtask

    initial begin
        test_reset();
        test_flat();
        test_phase_zero();
        test_rounding();
        test_premature_sob();
        test_gaps();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
